// File: rtl/sad_min_tracker.sv
// -----------------------------------------------------------------------------
// sad_min_tracker
//
// Sits downstream of the PE-array column selector. It takes one SAD per valid
// cycle for the candidate column named by sel_in and walks a 16x16 search
// window in raster order (columns within a row, rows top to bottom). It keeps
// the smallest SAD and the motion vector where that SAD occurred. When the
// last candidate has been taken in, it raises done for one cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse: begin a search (restarts an active search)
//   sad_valid  sad_in / sel_in carry a candidate this cycle
//   sel_in     candidate column index reported by the selector
//   sad_in     SAD of the candidate at (column, current row)
//   busy       search in progress
//   done       one-cycle pulse: best_sad / mv_x / mv_y hold the result
//   best_sad   minimum SAD found so far
//   mv_x       signed horizontal displacement (column - centre)
//   mv_y       signed vertical displacement (row - centre)
//   seq_err    sticky flag: sel_in disagreed with the expected column
// -----------------------------------------------------------------------------
module sad_min_tracker #(
  parameter int SAD_W     = 16,
  parameter int AXIS_LOG2 = 4,
  parameter int MV_W      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        sad_valid,
  input  logic [AXIS_LOG2-1:0]        sel_in,
  input  logic [SAD_W-1:0]            sad_in,
  output logic                        busy,
  output logic                        done,
  output logic [SAD_W-1:0]            best_sad,
  output logic signed [MV_W-1:0]      mv_x,
  output logic signed [MV_W-1:0]      mv_y,
  output logic                        seq_err
);

  localparam int CENTER = 1 << (AXIS_LOG2 - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                          r_state;
  logic [AXIS_LOG2-1:0]            r_col_cnt;
  logic [AXIS_LOG2-1:0]            r_row_cnt;
  logic [2*AXIS_LOG2-1:0]          r_cand_cnt;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_seq_err;
  logic [SAD_W-1:0]                r_best_sad;
  logic signed [MV_W-1:0]          r_mv_x;
  logic signed [MV_W-1:0]          r_mv_y;

  logic                            w_restart;
  logic                            w_accept;
  logic                            w_better;
  logic                            w_last;
  logic                            w_sel_bad;

  // Counter-to-displacement: zero-extend the index to MV_W bits, then remove
  // the window centre so index 0 maps to -CENTER and the top index to +CENTER-1.
  function automatic logic signed [MV_W-1:0] f_disp(input logic [AXIS_LOG2-1:0] cnt);
    logic [MV_W-1:0] ext;
    ext = MV_W'(cnt);
    return signed'(ext - MV_W'(CENTER));
  endfunction

  // A start in the DONE cycle is dropped; anywhere else it (re)launches a
  // search and takes precedence over a simultaneous sad_valid.
  assign w_restart = start && (r_state != S_DONE);
  assign w_accept  = (r_state == S_SEARCH) && sad_valid && !start;
  // Strict compare keeps the earliest candidate on ties.
  assign w_better  = sad_in < r_best_sad;
  assign w_last    = (r_cand_cnt == '1);
  assign w_sel_bad = sel_in != r_col_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_cand_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_seq_err  <= 1'b0;
      r_best_sad <= '1;
      r_mv_x     <= '0;
      r_mv_y     <= '0;
    end else if (w_restart) begin
      r_state    <= S_SEARCH;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_cand_cnt <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_seq_err  <= 1'b0;
      r_best_sad <= '1;
      r_mv_x     <= '0;
      r_mv_y     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
        end

        S_SEARCH: begin
          if (w_accept) begin
            if (w_sel_bad) begin
              r_seq_err <= 1'b1;
            end
            if (w_better) begin
              r_best_sad <= sad_in;
              r_mv_x     <= f_disp(r_col_cnt);
              r_mv_y     <= f_disp(r_row_cnt);
            end
            r_col_cnt  <= r_col_cnt + 1'b1;
            r_cand_cnt <= r_cand_cnt + 1'b1;
            if (r_col_cnt == '1) begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign best_sad = r_best_sad;
  assign mv_x     = r_mv_x;
  assign mv_y     = r_mv_y;
  assign seq_err  = r_seq_err;

endmodule

// File: tb/tb_sad_min_tracker.sv
// -----------------------------------------------------------------------------
// tb_sad_min_tracker
//
// Drives directed and randomised search windows into sad_min_tracker. A
// transaction-level model (accepted-candidate count, running minimum) predicts
// every output each cycle; literal expectations for the directed windows pin
// the model to hand-computed answers.
// -----------------------------------------------------------------------------
module tb_sad_min_tracker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sad_valid;
  logic [3:0]  sel_in;
  logic [15:0] sad_in;
  logic        busy;
  logic        done;
  logic [15:0] best_sad;
  logic signed [4:0] mv_x;
  logic signed [4:0] mv_y;
  logic        seq_err;

  sad_min_tracker #(.SAD_W(16), .AXIS_LOG2(4), .MV_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid),
    .sel_in(sel_in), .sad_in(sad_in), .busy(busy), .done(done),
    .best_sad(best_sad), .mv_x(mv_x), .mv_y(mv_y), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int unsigned pat [256];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: k = number of candidates accepted, column = k%16,
  // row = k/16, displacement = index - 8.
  logic        m_busy, m_done, m_err;
  int unsigned m_best;
  int          m_mvx, m_mvy, m_k;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_best <= 65535; m_mvx <= 0; m_mvy <= 0; m_k <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_done) begin
        m_busy <= 1'b0;
      end else if (start) begin
        m_busy <= 1'b1; m_err <= 1'b0; m_best <= 65535;
        m_mvx <= 0; m_mvy <= 0; m_k <= 0;
      end else if (m_busy && sad_valid) begin
        if (int'(sel_in) != m_k % 16) m_err <= 1'b1;
        if (int'(sad_in) < m_best) begin
          m_best <= sad_in;
          m_mvx  <= m_k % 16 - 8;
          m_mvy  <= m_k / 16 - 8;
        end
        m_k <= m_k + 1;
        if (m_k == 255) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    check("busy",     int'(busy),     int'(m_busy));
    check("done",     int'(done),     int'(m_done));
    check("seq_err",  int'(seq_err),  int'(m_err));
    check("best_sad", int'(best_sad), int'(m_best));
    check("mv_x",     int'(mv_x),     m_mvx);
    check("mv_y",     int'(mv_y),     m_mvy);
    if (done) n_done++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int c0;

  task automatic do_start(input bit with_valid);
    start = 1'b1; sad_valid = with_valid; sel_in = 4'd0; sad_in = 16'd0;
    c0 = cyc;
    tick;
    start = 1'b0; sad_valid = 1'b0;
  endtask

  // Feed candidates 0..n-1 from pat; optional random idle gaps (with a zero
  // SAD on the bus) between candidates; candidate 'bad_idx' reports column 6.
  task automatic feed(input int n, input int maxgap, input int bad_idx);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && maxgap > 0) begin
        sad_valid = 1'b0; sad_in = 16'd0; sel_in = 4'd0;
        repeat ($urandom_range(1, maxgap)) tick;
      end
      sad_valid = 1'b1;
      sel_in = (k == bad_idx) ? 4'd6 : 4'(k % 16);
      sad_in = 16'(pat[k]);
      tick;
    end
    sad_valid = 1'b0;
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic wait_done(input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check({nm, "_done_seen"}, int'(found), 1);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 256; i++) pat[i] = v;
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int i = 0; i < 256; i++) pat[i] = $urandom_range(hi, lo);
  endtask

  int d0;

  initial begin
    rst = 1'b1; start = 1'b0; sad_valid = 1'b0; sel_in = 4'd0; sad_in = 16'd0;
    repeat (3) tick;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_best", int'(best_sad), 65535);
    check("rst_mvx",  int'(mv_x), 0);
    check("rst_mvy",  int'(mv_y), 0);
    tick;
    rst = 1'b0;
    tick;

    // Single minimum at column 11, row 3.
    fill(1000); pat[3*16+11] = 40;
    do_start(1'b0);
    feed(256, 0, -1);
    wait_done("a");
    check("a_latency", cyc - c0, 257);
    check("a_best", int'(best_sad), 40);
    check("a_mvx",  int'(mv_x), 3);
    check("a_mvy",  int'(mv_y), -5);
    check("a_busy", int'(busy), 0);
    tick;

    // Tie: first occurrence in raster order wins; start in DONE is dropped.
    fill(500); pat[8*16+8] = 200; pat[14*16+2] = 200;
    do_start(1'b0);
    feed(256, 0, -1);
    wait_done("b");
    check("b_best", int'(best_sad), 200);
    check("b_mvx",  int'(mv_x), 0);
    check("b_mvy",  int'(mv_y), 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clk);
    check("b_start_in_done_busy", int'(busy), 0);
    tick;

    // Stalls between candidates; minimum at the very last position.
    fill_rand(8, 65534); pat[255] = 7;
    do_start(1'b0);
    feed(200, 5, -1);
    repeat (3) tick;
    @(negedge clk);
    check("c_busy_mid", int'(busy), 1);
    tick;
    for (int i = 200; i < 256; i++) pat[i - 200] = pat[i];
    feed(56, 5, -1);
    wait_done("c");
    check("c_best", int'(best_sad), 7);
    check("c_mvx",  int'(mv_x), 7);
    check("c_mvy",  int'(mv_y), 7);
    tick;

    // Abort after 50 candidates; restart carries a sad_valid that is dropped.
    d0 = n_done;
    fill_rand(10, 65534);
    do_start(1'b0);
    feed(50, 0, -1);
    do_start(1'b1);
    fill_rand(10, 65534); pat[0] = 9;
    feed(256, 0, -1);
    wait_done("d");
    check("d_best", int'(best_sad), 9);
    check("d_mvx",  int'(mv_x), -8);
    check("d_mvy",  int'(mv_y), -8);
    tick;
    check("d_done_count", n_done - d0, 1);

    // Column sequence jumps 4 -> 6 in row 2.
    fill_rand(0, 65534);
    do_start(1'b0);
    feed(256, 2, 2*16+5);
    wait_done("e");
    check("e_seq_err", int'(seq_err), 1);
    tick;
    do_start(1'b0);
    @(negedge clk);
    check("e_seq_err_clr", int'(seq_err), 0);
    tick;
    fill(777);
    feed(256, 0, -1);
    wait_done("f");
    check("f_best", int'(best_sad), 777);
    check("f_mvx",  int'(mv_x), -8);
    check("f_mvy",  int'(mv_y), -8);
    tick;

    // Reset in the middle of a search.
    d0 = n_done;
    fill_rand(1, 65534);
    do_start(1'b0);
    feed(100, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    check("g_rst_busy", int'(busy), 0);
    check("g_rst_best", int'(best_sad), 65535);
    check("g_rst_mvx",  int'(mv_x), 0);
    tick;
    rst = 1'b0;
    repeat (4) tick;
    check("g_no_done", n_done - d0, 0);

    // All-ones SADs never beat the initial best.
    fill(65535);
    do_start(1'b0);
    feed(256, 1, -1);
    wait_done("h");
    check("h_best", int'(best_sad), 65535);
    check("h_mvx",  int'(mv_x), 0);
    check("h_mvy",  int'(mv_y), 0);
    tick;

    // Random windows with a narrow value range to force ties.
    for (int r = 0; r < 3; r++) begin
      fill_rand(0, 40);
      do_start(1'b0);
      feed(256, 3, -1);
      wait_done("rnd");
      tick;
    end

    repeat (3) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
